// File: rtl/headlight_pwm_driver.sv
// Headlight lamp PWM driver: 255-tick PWM with per-period soft ramping of the duty toward the requested level.
// Latency: duty/state move only at period boundaries; lamp_pwm lags cnt/duty by one clk.
// Backpressure: none; the prescaler and PWM counter free-run and never stall.
module headlight_pwm_driver #(
    parameter int PRESCALE  = 4,
    parameter int RAMP_STEP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       headlights_in,
    input  logic [7:0] dim_level_in,
    output logic       lamp_pwm,
    output logic [7:0] duty,
    output logic [1:0] state,
    output logic       ramp_busy,
    output logic       period_start
);

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);
    localparam logic [8:0] STEP      = 9'(RAMP_STEP);

    state_t     state_q, state_nxt;
    logic [7:0] presc, cnt;
    logic [7:0] duty_q, duty_nxt;
    logic       tick;
    logic [8:0] target, duty_w, diff, delta;

    assign tick         = (presc == PRESC_MAX);
    // High during the clk whose closing edge wraps cnt 254->0; that edge is the boundary.
    assign period_start = tick && (cnt == 8'd254);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            presc <= tick ? 8'd0 : presc + 8'd1;
            if (tick) begin
                cnt <= (cnt == 8'd254) ? 8'd0 : cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            duty_q   <= '0;
            lamp_pwm <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            duty_q   <= duty_nxt;
            lamp_pwm <= (cnt < duty_q);
        end
    end

    // Ramp arithmetic is 9 bits wide so a step near 255 can neither wrap nor pass the target.
    always_comb begin
        state_nxt = state_q;
        duty_nxt  = duty_q;
        target    = '0;
        duty_w    = {1'b0, duty_q};
        diff      = '0;
        delta     = '0;
        if (period_start) begin
            target = headlights_in ? {1'b0, dim_level_in} : 9'd0;
            if (duty_w < target) begin
                diff   = target - duty_w;
                delta  = (diff < STEP) ? diff : STEP;
                duty_w = duty_w + delta;
            end else if (duty_w > target) begin
                diff   = duty_w - target;
                delta  = (diff < STEP) ? diff : STEP;
                duty_w = duty_w - delta;
            end
            duty_nxt = duty_w[7:0];
            if (duty_w == target) begin
                state_nxt = (target == 9'd0) ? ST_OFF : ST_ON;
            end else if (duty_w < target) begin
                state_nxt = ST_RAMP_UP;
            end else begin
                state_nxt = ST_RAMP_DOWN;
            end
        end
    end

    assign duty      = duty_q;
    assign state     = state_q;
    assign ramp_busy = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

endmodule

// File: tb/tb_headlight_pwm_driver.sv
// Directed bench for headlight_pwm_driver at PRESCALE=1, RAMP_STEP=8.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_headlight_pwm_driver;

    logic       clk;
    logic       rst_n;
    logic       headlights_in;
    logic [7:0] dim_level_in;
    logic       lamp_pwm;
    logic [7:0] duty;
    logic [1:0] state;
    logic       ramp_busy;
    logic       period_start;

    int checks = 0;
    int errors = 0;

    headlight_pwm_driver #(
        .PRESCALE (1),
        .RAMP_STEP(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .headlights_in(headlights_in),
        .dim_level_in (dim_level_in),
        .lamp_pwm     (lamp_pwm),
        .duty         (duty),
        .state        (state),
        .ramp_busy    (ramp_busy),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the falling edge just after the next boundary edge.
    task automatic wait_boundary();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                seen = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
        end
        if (!seen) chk("boundary_timeout", 32'd0, 32'd1);
    endtask

    // Counts rising edges after reset release up to and including the first boundary edge.
    task automatic measure_first(output int n);
        bit ps;
        n  = 0;
        ps = 1'b0;
        for (int k = 0; k < 600 && !ps; k++) begin
            @(negedge clk);
            ps = (period_start === 1'b1);
            @(posedge clk);
            n++;
        end
    endtask

    function automatic int exp_duty(input int start, input int tgt, input int i);
        int v;
        if (start < tgt) begin
            v = start + 8 * i;
            return (v > tgt) ? tgt : v;
        end
        v = start - 8 * i;
        return (v < tgt) ? tgt : v;
    endfunction

    function automatic int exp_state(input int d, input int tgt);
        if (d == tgt) return (tgt == 0) ? 0 : 2;
        return (d < tgt) ? 1 : 3;
    endfunction

    task automatic ramp(input string tag, input int start, input int tgt, input int first, input int last);
        int e;
        for (int i = first; i <= last; i++) begin
            wait_boundary();
            e = exp_duty(start, tgt, i);
            chk({tag, "_duty"}, 32'(duty), 32'(e));
            chk({tag, "_state"}, 32'(state), 32'(exp_state(e, tgt)));
            chk({tag, "_busy"}, 32'(ramp_busy), 32'(exp_state(e, tgt) % 2));
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        @(negedge clk);
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            if (lamp_pwm === 1'b1) n++;
        end
    endtask

    int n;

    initial begin
        headlights_in = 1'b0;
        dim_level_in  = 8'd0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lamp", 32'(lamp_pwm), 32'd0);
        chk("rst_busy", 32'(ramp_busy), 32'd0);
        chk("rst_pstart", 32'(period_start), 32'd0);

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        measure_first(n);
        chk("first_boundary_clk", 32'(n), 32'd255);
        @(negedge clk);
        chk("idle_duty", 32'(duty), 32'd0);
        chk("idle_state", 32'(state), 32'd0);

        // Reversal: climb toward 200, then retarget 40 at duty 64.
        headlights_in = 1'b1;
        dim_level_in  = 8'd200;
        ramp("up200", 0, 200, 1, 8);
        chk("rev_at64", 32'(duty), 32'd64);
        dim_level_in = 8'd40;
        wait_boundary();
        chk("rev_duty56", 32'(duty), 32'd56);
        chk("rev_state_down", 32'(state), 32'd3);
        wait_boundary();
        chk("rev_duty48", 32'(duty), 32'd48);
        wait_boundary();
        chk("rev_duty40", 32'(duty), 32'd40);
        chk("rev_state_on", 32'(state), 32'd2);
        chk("rev_busy", 32'(ramp_busy), 32'd0);

        // Climb to 96 again, then pull reset between edges.
        dim_level_in = 8'd200;
        ramp("up96", 40, 200, 1, 7);
        chk("pre_rst_duty", 32'(duty), 32'd96);
        dim_level_in = 8'd128;
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_duty", 32'(duty), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_lamp", 32'(lamp_pwm), 32'd0);
        chk("arst_busy", 32'(ramp_busy), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        measure_first(n);
        chk("arst_first_boundary_clk", 32'(n), 32'd255);
        @(negedge clk);
        chk("up128_duty_b1", 32'(duty), 32'd8);
        chk("up128_state_b1", 32'(state), 32'd1);

        ramp("up128", 0, 128, 2, 16);
        chk("up128_final", 32'(duty), 32'd128);
        count_high(n);
        chk("pwm_high_128", 32'(n), 32'd128);

        // Glitch on dim_level_in well away from the boundary.
        repeat (20) @(negedge clk);
        dim_level_in = 8'd0;
        repeat (10) @(negedge clk);
        dim_level_in = 8'd128;
        wait_boundary();
        chk("glitch_duty", 32'(duty), 32'd128);
        chk("glitch_state", 32'(state), 32'd2);

        headlights_in = 1'b0;
        ramp("off128", 128, 0, 1, 16);
        chk("off128_state", 32'(state), 32'd0);

        headlights_in = 1'b1;
        dim_level_in  = 8'd255;
        ramp("up255", 0, 255, 1, 32);
        chk("full_duty", 32'(duty), 32'd255);
        chk("full_state", 32'(state), 32'd2);
        count_high(n);
        chk("pwm_high_255", 32'(n), 32'd255);

        headlights_in = 1'b0;
        ramp("off255", 255, 0, 1, 32);
        chk("dark_duty", 32'(duty), 32'd0);
        chk("dark_state", 32'(state), 32'd0);
        count_high(n);
        chk("pwm_high_0", 32'(n), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/headlight_pwm_driver.md
HEADLIGHT_PWM_DRIVER -- requirements
Module: headlight_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clk cycles per PWM counter tick, legal range 1..255.
REQ-002 SHALL have parameter RAMP_STEP, default 8: maximum duty change per PWM period, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port headlights_in, input, 1 bit: lamp request from the headlight controller (1 = on).
REQ-006 SHALL have port dim_level_in, input, 8 bits: requested brightness (0 = off, 255 = full).
REQ-007 SHALL have port lamp_pwm, output, 1 bit: registered PWM drive to the lamp power stage.
REQ-008 SHALL have port duty, output, 8 bits: current applied duty.
REQ-009 SHALL have port state, output, 2 bits: OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3.
REQ-010 SHALL have port ramp_busy, output, 1 bit: high exactly when state is RAMP_UP or RAMP_DOWN.
REQ-011 SHALL have port period_start, output, 1 bit: one-clk pulse at each PWM period boundary.

Function
REQ-012 SHALL run a prescaler counting 0..PRESCALE-1 and emit a tick in the clk where it equals PRESCALE-1, then wrap to 0.
REQ-013 SHALL advance the 8-bit PWM counter cnt on each tick, running 0..254 and wrapping 254->0, giving a 255-tick period.
REQ-014 SHALL assert period_start for exactly the clk in which cnt wraps 254->0; it SHALL NOT pulse on the first tick after reset.
REQ-015 SHALL compute target = dim_level_in when headlights_in=1, else target = 0, sampled only in the period_start clk.
REQ-016 SHALL change duty only at the period_start edge: if duty<target, duty += min(RAMP_STEP, target-duty); if duty>target, duty -= min(RAMP_STEP, duty-target); otherwise duty holds.
REQ-017 SHALL perform duty arithmetic at 9 bits or wider, so duty never wraps and never overshoots target.
REQ-018 SHALL ignore input changes between boundaries; only the value present in the period_start clk matters.
REQ-019 SHALL update state at the same edge as duty, from the new duty and sampled target:
- new duty = target = 0 -> OFF
- new duty = target != 0 -> ON
- new duty < target -> RAMP_UP
- new duty > target -> RAMP_DOWN
REQ-020 SHALL let a target reversal mid-ramp move state directly between RAMP_UP and RAMP_DOWN at that boundary.
REQ-021 SHALL register lamp_pwm every clk as (cnt < duty), using current register values, giving one clk of lag.
- duty=0 -> lamp_pwm constantly 0.
- duty=255 -> lamp_pwm constantly 1.
- duty=D -> exactly D high ticks per 255-tick period.
REQ-022 SHALL not stall the prescaler or cnt for any input value; the PWM period is fixed at 255*PRESCALE clk.

Reset
REQ-023 SHALL, while rst_n=0 and with no clk edge required, force prescaler=0, cnt=0, duty=0, state=OFF, lamp_pwm=0, ramp_busy=0, period_start=0.
REQ-024 SHALL, on rst_n low mid-ramp, abandon the ramp, with no residual duty after release.
REQ-025 SHALL restart counting from 0 after rst_n deassertion; the first period_start occurs 255*PRESCALE clk later.

Verification (PRESCALE=1, RAMP_STEP=8)
REQ-026 SHALL cover ramp up: headlights_in=1, dim_level_in=128 from OFF -> duty 8,16,...,128 over 16 boundaries; RAMP_UP with ramp_busy=1, then ON at the 16th; then 128 high clk per 255.
REQ-027 SHALL cover full brightness: dim_level_in=255 from OFF -> duty reaches 248 after 31 boundaries, 255 at the 32nd (step 7); ON; lamp_pwm constantly 1.
REQ-028 SHALL cover switch-off: from ON at 255, headlights_in=0 -> duty 247,239,...,7, then 0 at the 32nd boundary; RAMP_DOWN, then OFF; lamp_pwm constantly 0.
REQ-029 SHALL cover reversal: in RAMP_UP at duty 64 (target 200), dim_level_in changed to 40 -> next boundary duty 56, RAMP_DOWN; then 48, 40, ON.
REQ-030 SHALL cover mid-period input glitch: dim_level_in pulses to 0 for 10 clk, not spanning period_start, in ON at 128 -> duty stays 128, no state change.
REQ-031 SHALL cover async reset: rst_n low between clk edges during RAMP_UP at duty 96 -> duty=0, lamp_pwm=0, state=OFF immediately; first period_start 255 clk after release.
